// File: rtl/pla_vector_sequencer.sv
// Stimulus sequencer for a flat combinational PLA: drives a vector onto x, waits
// a programmable settle time, captures z, and emits a pass/fail record with counters.
module pla_vector_sequencer #(
  parameter int unsigned NUM_IN  = 39,
  parameter int unsigned NUM_OUT = 8,
  parameter int unsigned SETTLE  = 2,
  parameter int unsigned CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [NUM_IN-1:0]  in_vec,
  input  logic [NUM_OUT-1:0] in_exp,
  input  logic [NUM_OUT-1:0] in_mask,
  output logic [NUM_IN-1:0]  pla_x,
  input  logic [NUM_OUT-1:0] pla_z,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [NUM_OUT-1:0] out_z,
  output logic               out_miss,
  output logic [CNT_W-1:0]   out_idx,
  output logic [CNT_W-1:0]   vec_count,
  output logic [CNT_W-1:0]   err_count,
  output logic [1:0]         dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both
  // high. The producer holds valid and its payload stable until that edge; ready
  // never depends combinationally on valid. Both sides here are fully registered.

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_REPORT = 2'd2
  } state_t;

  localparam logic [7:0]       SETTLE_INIT = 8'(SETTLE - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  state_t             state;
  logic [7:0]         settle_cnt;
  logic [NUM_OUT-1:0] exp_r;
  logic [NUM_OUT-1:0] mask_r;

  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      settle_cnt <= '0;
      exp_r      <= '0;
      mask_r     <= '0;
      pla_x      <= '0;
      in_ready   <= 1'b0;
      out_valid  <= 1'b0;
      out_z      <= '0;
      out_miss   <= 1'b0;
      out_idx    <= '0;
      vec_count  <= '0;
      err_count  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            pla_x      <= in_vec;
            exp_r      <= in_exp;
            mask_r     <= in_mask;
            out_idx    <= vec_count;
            settle_cnt <= SETTLE_INIT;
            in_ready   <= 1'b0;
            state      <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          // pla_z is only looked at on the capture edge, so settle-time glitches are harmless
          if (settle_cnt == '0) begin
            out_z     <= pla_z;
            out_miss  <= |((pla_z ^ exp_r) & mask_r);
            out_valid <= 1'b1;
            state     <= ST_REPORT;
          end else begin
            settle_cnt <= settle_cnt - 8'd1;
          end
        end
        ST_REPORT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: begin
          in_ready <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase

      // clear takes priority over a coinciding result handshake
      if (clear) begin
        vec_count <= '0;
        err_count <= '0;
      end else if (state == ST_REPORT && out_valid && out_ready) begin
        if (vec_count != CNT_MAX) vec_count <= vec_count + 1'b1;
        if (out_miss && err_count != CNT_MAX) err_count <= err_count + 1'b1;
      end
    end
  end

endmodule
